// File: rtl/rom_port_arbiter_if.sv
// rtl/rom_port_arbiter_if.sv - requester and ROM signal bundle for rom_port_arbiter.
// slave modport is the arbiter side; master is the requesters plus ROM.
interface rom_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;

  modport slave (
    input  req0, addr0, req1, addr1, rom_dout,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );

  modport master (
    output req0, addr0, req1, addr1, rom_dout,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_addr
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - two-port arbiter for a 1-cycle-latency ROM with port 1 starvation bound.
// Optional macro ARB_RR_EN replaces fixed priority with round-robin on contention.
module rom_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               reset,
  rom_port_arbiter_if.slave  bus
);

  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] rom_addr;
  logic              resp_v_q, resp_v_d;
  logic              resp_id_q, resp_id_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              rvalid0;
  logic              rvalid1;

`ifdef ARB_RR_EN
  logic last_winner_q, last_winner_d;

  // On contention the port that did not win most recently gets the ROM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    last_winner_d = last_winner_q;
    if (!reset) begin
      if (bus.req0 && bus.req1) begin
        gnt0 = last_winner_q;
        gnt1 = !last_winner_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
    if (gnt1) begin
      last_winner_d = 1'b1;
    end else if (gnt0) begin
      last_winner_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= 1'b1;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end
`else
  localparam logic [3:0] STARVE_W = 4'(STARVE_MAX);

  logic [3:0] wait1_q, wait1_d;

  // Port 0 has priority until port 1 has been denied STARVE_MAX cycles in a row.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (bus.req1 && (!bus.req0 || wait1_q == STARVE_W)) begin
        gnt1 = 1'b1;
      end else if (bus.req0) begin
        gnt0 = 1'b1;
      end
    end
    wait1_d = wait1_q;
    if (gnt1 || !bus.req1) begin
      wait1_d = 4'd0;
    end else if (wait1_q != STARVE_W) begin
      wait1_d = wait1_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait1_q <= 4'd0;
    end else begin
      wait1_q <= wait1_d;
    end
  end
`endif

  always_comb begin
    rom_addr    = last_addr_q;
    if (gnt1) begin
      rom_addr = bus.addr1;
    end else if (gnt0) begin
      rom_addr = bus.addr0;
    end
    last_addr_d = rom_addr;
    resp_v_d    = gnt0 | gnt1;
    resp_id_d   = gnt1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_v_q    <= 1'b0;
      resp_id_q   <= 1'b0;
      last_addr_q <= '0;
    end else begin
      resp_v_q    <= resp_v_d;
      resp_id_q   <= resp_id_d;
      last_addr_q <= last_addr_d;
    end
  end

  // A response still in flight when reset asserts is dropped, not delivered.
  assign rvalid0 = resp_v_q && !resp_id_q && !reset;
  assign rvalid1 = resp_v_q && resp_id_q && !reset;

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rom_addr = rom_addr;
  assign bus.rvalid0  = rvalid0;
  assign bus.rvalid1  = rvalid1;
  assign bus.rdata0   = rvalid0 ? bus.rom_dout : '0;
  assign bus.rdata1   = rvalid1 ? bus.rom_dout : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - scoreboard bench for rom_port_arbiter with ROM model and arbitration reference.
// Build with ARB_RR_EN defined to check the round-robin variant.
module tb_rom_port_arbiter;

  localparam int STARVE = 3;

  typedef struct {
    bit         port;
    logic [9:0] addr;
    int         due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   done;

  logic [31:0] mem [1024];
  exp_t        q [$];

  int         denied;
  bit         last_w;
  logic [9:0] m_last_addr;

  rom_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  rom_port_arbiter #(
    .ADDR_W    (10),
    .DATA_W    (32),
    .STARVE_MAX(STARVE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.rom_dout <= mem[bus.rom_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit r0, input logic [9:0] a0,
                      input bit r1, input logic [9:0] a1);
    bit         g0;
    bit         g1;
    logic [9:0] ea;
    exp_t       e;
    @(posedge clk);
    #1;
    reset     = rst;
    bus.req0  = r0;
    bus.addr0 = a0;
    bus.req1  = r1;
    bus.addr1 = a1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due == cyc) q.delete(i);
      end
    end else begin
`ifdef ARB_RR_EN
      if (r0 && r1) begin
        g0 = last_w;
        g1 = !last_w;
      end else begin
        g0 = r0;
        g1 = r1;
      end
`else
      g1 = r1 && (!r0 || denied >= STARVE);
      g0 = r0 && !g1;
`endif
      if (g0 || g1) begin
        e.port = g1;
        e.addr = g1 ? a1 : a0;
        e.due  = cyc + 1;
        q.push_back(e);
      end
    end
    ea = g1 ? a1 : (g0 ? a0 : m_last_addr);
    @(negedge clk);
    chk("gnt0", 64'(bus.gnt0), 64'(g0));
    chk("gnt1", 64'(bus.gnt1), 64'(g1));
    if (!rst) chk("rom_addr", 64'(bus.rom_addr), 64'(ea));
    if (rst) begin
      denied      = 0;
      last_w      = 1'b1;
      m_last_addr = '0;
    end else begin
      m_last_addr = ea;
      if (g1 || !r1) denied = 0;
      else if (denied < STARVE) denied++;
      if (g0) last_w = 1'b0;
      if (g1) last_w = 1'b1;
    end
  endtask

  // Monitor: every cycle either the oldest expected response is due, or the outputs must be idle.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rvalid0", 64'(bus.rvalid0), 64'(e.port == 1'b0));
        chk("rvalid1", 64'(bus.rvalid1), 64'(e.port == 1'b1));
        chk("rdata0", 64'(bus.rdata0), e.port ? 64'd0 : 64'(mem[e.addr]));
        chk("rdata1", 64'(bus.rdata1), e.port ? 64'(mem[e.addr]) : 64'd0);
      end else begin
        chk("idle_rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'd0);
        chk("idle_rdata", {bus.rdata0, bus.rdata1}, 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    mem[5]    = 32'hDEADBEEF;
    mem[1023] = 32'h12345678;
    cyc = 0; n_checks = 0; n_fail = 0; done = 1'b0;
    denied = 0; last_w = 1'b1; m_last_addr = '0;
    reset = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 10'd7;
    bus.req1 = 1'b1; bus.addr1 = 10'd9;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'd7, 1'b1, 10'd9);
    step(1'b0, 1'b1, 10'd7, 1'b1, 10'd9);
    step(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);

    step(1'b0, 1'b1, 10'd5, 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 10'(i + 16), 1'b1, 10'(i + 600));
    step(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);

    step(1'b0, 1'b0, 10'd0, 1'b1, 10'h3FF);
    step(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);

    step(1'b0, 1'b1, 10'd5, 1'b1, 10'd77);
    step(1'b1, 1'b1, 10'd5, 1'b1, 10'd77);
    step(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b1, 10'd3);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, 10'($urandom),
           $urandom_range(0, 2) != 0, 10'($urandom));
    end
    step(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0, 10'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
